pcm_playback_ctrl: RTL and testbench
====================================

# pcm_playback_ctrl

Sequencer that plays a mono 32-bit PCM song stored in a single-port synchronous RAM through the Audio_Controller output FIFO. It owns the RAM read address, waits out the RAM read latency, and offers one sample per Audio_Controller `audio_out_allowed` slot via `write_audio_out`. It supports start/stop/pause, optional looping and an optional volume attenuator. It sits between the top level (switches/keys), the song RAM and the Audio_Controller.

## Interface
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 32: sample width, signed two's complement.
- `SONG_LEN`, 45853: number of samples; valid addresses are 0..SONG_LEN-1.
- `RAM_LAT`, 1: RAM clock cycles from address to `ram_q` valid, 1..3.

Ports:
- `CLOCK_50` in 1: system clock; all logic on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: level, sampled each cycle; begins playback from address 0.
- `stop` in 1: level; aborts playback and returns to idle.
- `pause` in 1: level; holds playback at the current sample.
- `loop_en` in 1: when high, playback wraps to 0 after the last sample instead of finishing.
- `vol` in 3: attenuation shift, 0 = full scale. Used only with PCM_VOLUME_EN.
- `ram_addr` out ADDR_W: RAM read address, registered.
- `ram_q` in DATA_W: RAM read data.
- `audio_out_allowed` in 1: Audio_Controller output FIFO has space.
- `write_audio_out` out 1: one-cycle write strobe to the Audio_Controller.
- `left_channel_audio_out`, `right_channel_audio_out` out DATA_W: sample, registered; both channels carry the same value.
- `playing` out 1: high in FETCH or READY.
- `done` out 1: high in DONE.

## Operation
- States:
  - IDLE: `ram_addr` = 0.
  - FETCH: latency counter `lat_cnt` is running.
  - READY: the sample is latched and waiting for a slot.
  - DONE: the song has finished with `loop_en` low.
- Reset: state IDLE, `ram_addr` 0, `lat_cnt` 0, both channel outputs 0, `write_audio_out` 0, `playing` 0, `done` 0.
- Priority: `stop` > `start` > all other transitions.
- `stop` high in any state: next state IDLE and `ram_addr` <= 0. `write_audio_out` is forced low in that same cycle.
- IDLE or DONE, with `start` high and `stop` low: go to FETCH, `ram_addr` <= 0, `lat_cnt` <= 0.
- `start` in FETCH or READY is ignored; it does not restart playback.
- FETCH: `lat_cnt` increments each cycle. On the cycle where `lat_cnt` == RAM_LAT, latch `ram_q` (attenuated, see Configuration) into both channel registers and go to READY. `pause` does not stall FETCH.
- READY: `write_audio_out` = `audio_out_allowed` & ~`pause` & ~`stop`, combinational. On a write cycle:
  - If `ram_addr` < SONG_LEN-1: `ram_addr` increments and the state goes to FETCH.
  - If `ram_addr` == SONG_LEN-1 and `loop_en` is high: `ram_addr` <= 0 and the state goes to FETCH.
  - If `ram_addr` == SONG_LEN-1 and `loop_en` is low: go to DONE and `ram_addr` <= 0.
- `loop_en` is sampled only at the last-sample write.
- Each sample is written exactly once. Samples are never skipped or repeated, except on the wrap from SONG_LEN-1 to 0.
- Channel outputs hold their last value in IDLE and DONE. They are not cleared by `stop`.

## Timing
- `start` sampled high at edge t: FETCH from t+1, sample latched at edge t+1+RAM_LAT, READY from t+2+RAM_LAT.
- Earliest `write_audio_out` is in cycle t+2+RAM_LAT.
- Sample period, with `audio_out_allowed` continuously high: RAM_LAT+2 cycles per sample.
- `ram_addr` is stable for the full FETCH window of each sample.
- `write_audio_out` lasts exactly one cycle per sample; READY exits on the following edge.
- Async reset asserted mid-operation: all outputs reach their reset values immediately. After release, the block stays in IDLE until `start` is seen.

## Configuration
- `PCM_VOLUME_EN` defined: latched sample = `ram_q` >>> `vol`. This is a signed arithmetic shift that sign-extends; `vol` is sampled at the latch edge.
- `PCM_VOLUME_EN` undefined: latched sample = `ram_q` unmodified; `vol` is unused.

## Test plan
- Reset then `start` pulse, SONG_LEN=4, RAM_LAT=1, RAM[i]=i+1, `audio_out_allowed`=1, `loop_en`=0:
  - Writes carry 1,2,3,4, three cycles apart, first write in cycle t+3.
  - `done`=1 after the fourth write; `ram_addr`=0.
- Same setup with `loop_en`=1: the write sequence is 1,2,3,4,1,2,… with no gap at the wrap.
- Hold `audio_out_allowed`=0 for 20 cycles while in READY:
  - No write occurs and the sample and `ram_addr` stay constant.
  - When `audio_out_allowed` returns to 1, the held sample is written once.
- `pause` high during FETCH: FETCH completes and the block waits in READY with no write; on release, the next write carries the expected sample.
- `stop` and `start` asserted together in READY with `audio_out_allowed`=1:
  - No write in that cycle.
  - State goes to IDLE and `ram_addr`=0; `start` is ignored.
- With `PCM_VOLUME_EN` defined, `ram_q`=32'hFFFF_0000 and `vol`=4: the output is 32'hFFFF_F000. Without the macro, the output is 32'hFFFF_0000.

Source files
------------

// File: rtl/pcm_playback_ctrl.sv
// pcm_playback_ctrl: plays a mono PCM song from a synchronous RAM into the Audio_Controller
// output FIFO, one sample per audio_out_allowed slot. Define PCM_VOLUME_EN to enable the vol attenuator.
module pcm_playback_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int SONG_LEN = 45853,
  parameter int RAM_LAT  = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic                     loop_en,
  input  logic [2:0]               vol,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic signed [DATA_W-1:0] ram_q,
  input  logic                     audio_out_allowed,
  output logic                     write_audio_out,
  output logic signed [DATA_W-1:0] left_channel_audio_out,
  output logic signed [DATA_W-1:0] right_channel_audio_out,
  output logic                     playing,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [1:0]        LAT_END   = 2'(RAM_LAT);

  state_t                   state, state_nxt;
  logic [1:0]               lat_cnt;
  logic                     last_sample;
  logic                     launch;
  logic                     wr;
  logic                     vld_p0;
  logic signed [DATA_W-1:0] sample_p0;

`ifdef PCM_VOLUME_EN
  function automatic logic signed [DATA_W-1:0] attenuate(
    input logic signed [DATA_W-1:0] s,
    input logic [2:0]               sh
  );
    return s >>> sh;
  endfunction

  assign sample_p0 = attenuate(ram_q, vol);
`else
  logic unused_vol;
  assign unused_vol = ^vol;
  assign sample_p0  = ram_q;
`endif

  assign last_sample = (ram_addr == LAST_ADDR);
  assign launch      = start && !stop && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    vld_p0    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (lat_cnt == LAT_END) begin
          vld_p0    = 1'b1;
          state_nxt = READY;
        end
      end
      READY: begin
        wr = audio_out_allowed && !pause;
        if (wr) state_nxt = (last_sample && !loop_en) ? DONE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
    // stop outranks everything, including a write already offered this cycle
    if (stop) begin
      state_nxt = IDLE;
      wr        = 1'b0;
      vld_p0    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ram_addr <= '0;
      lat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (stop) begin
        ram_addr <= '0;
        lat_cnt  <= '0;
      end else if (launch) begin
        ram_addr <= '0;
        lat_cnt  <= '0;
      end else if (wr) begin
        ram_addr <= last_sample ? '0 : ram_addr + 1'b1;
        lat_cnt  <= '0;
      end else if ((state == FETCH) && !vld_p0) begin
        lat_cnt <= lat_cnt + 2'd1;
      end
    end
  end

  // p0 -> p1: latched sample, held until the next fetch completes
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else if (vld_p0) begin
      left_channel_audio_out  <= sample_p0;
      right_channel_audio_out <= sample_p0;
    end
  end

  assign write_audio_out = wr;
  assign playing         = (state == FETCH) || (state == READY);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_pcm_playback_ctrl.sv
// Self-checking bench for pcm_playback_ctrl: short song in a modelled RAM, writes collected
// by a monitor and compared against the sample order/timing derived from the playback rules.
module tb_pcm_playback_ctrl;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int SONG_LEN = 4;
  localparam int RAM_LAT  = 1;
  localparam int PERIOD   = RAM_LAT + 2;
`ifdef PCM_VOLUME_EN
  localparam bit VOL_ON = 1'b1;
`else
  localparam bit VOL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     resetn, start, stop, pause, loop_en, audio_out_allowed;
  logic [2:0]               vol;
  logic [ADDR_W-1:0]        ram_addr;
  logic signed [DATA_W-1:0] ram_q;
  logic                     write_audio_out, playing, done;
  logic signed [DATA_W-1:0] left_out, right_out;

  logic [DATA_W-1:0] mem [SONG_LEN];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int               q_cyc[$];
  logic [DATA_W-1:0] q_l[$];
  logic [DATA_W-1:0] q_r[$];

  pcm_playback_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SONG_LEN(SONG_LEN), .RAM_LAT(RAM_LAT)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .vol(vol), .ram_addr(ram_addr), .ram_q(ram_q),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_out), .right_channel_audio_out(right_out),
    .playing(playing), .done(done)
  );

  // single-cycle-latency synchronous RAM
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_addr < ADDR_W'(SONG_LEN)) ram_q <= mem[ram_addr[1:0]];
    else                               ram_q <= 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (write_audio_out) begin
      q_cyc.push_back(cyc);
      q_l.push_back(left_out);
      q_r.push_back(right_out);
    end
  end

  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] v, input logic [2:0] s);
    int sh;
    sh = VOL_ON ? int'(s) : 0;
    return $signed(v) >>> sh;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_q();
    q_cyc.delete();
    q_l.delete();
    q_r.delete();
  endtask

  task automatic start_pulse(output int s);
    s = cyc + 1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 0; stop = 0; pause = 0; loop_en = 0; audio_out_allowed = 0; vol = 0;
    for (int i = 0; i < SONG_LEN; i++) mem[i] = DATA_W'(i + 1);
    run(3);
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b want 0", playing); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (write_audio_out !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", write_audio_out); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
    checks++; if (left_out !== '0 || right_out !== '0) begin errors++; $display("FAIL reset_channels: got %h/%h want 0/0", left_out, right_out); end
    resetn = 1'b1;
    clear_q();
    run(4);
    checks++; if (playing !== 1'b0 || q_cyc.size() != 0) begin errors++; $display("FAIL reset_stays_idle: playing %b writes %0d want 0/0", playing, q_cyc.size()); end
  endtask

  task automatic test_play_once();
    int s;
    loop_en = 0; audio_out_allowed = 1; vol = 0;
    for (int i = 0; i < SONG_LEN; i++) mem[i] = DATA_W'(i + 1);
    clear_q();
    start_pulse(s);
    for (int k = 0; k < 40 && !done; k++) step();
    checks++; if (q_cyc.size() != SONG_LEN) begin errors++; $display("FAIL once_count: got %0d want %0d", q_cyc.size(), SONG_LEN); end
    for (int i = 0; i < SONG_LEN && i < q_cyc.size(); i++) begin
      checks++; if (q_l[i] !== DATA_W'(i + 1)) begin errors++; $display("FAIL once_value[%0d]: got %h want %h", i, q_l[i], i + 1); end
      checks++; if (q_cyc[i] != s + RAM_LAT + 1 + i * PERIOD) begin errors++; $display("FAIL once_timing[%0d]: got cycle %0d want %0d", i, q_cyc[i], s + RAM_LAT + 1 + i * PERIOD); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL once_done: got %b want 1", done); end
    checks++; if (ram_addr !== '0 || playing !== 1'b0) begin errors++; $display("FAIL once_end_state: addr %0d playing %b want 0/0", ram_addr, playing); end
    run(3);
    checks++; if (q_cyc.size() != SONG_LEN || done !== 1'b1) begin errors++; $display("FAIL once_stays_done: writes %0d done %b want %0d/1", q_cyc.size(), done, SONG_LEN); end
  endtask

  task automatic test_loop();
    int s, n;
    logic [DATA_W-1:0] l_hold;
    loop_en = 1; audio_out_allowed = 1; vol = 3'($urandom_range(0, 7));
    for (int i = 0; i < SONG_LEN; i++) mem[i] = $urandom;
    clear_q();
    start_pulse(s);
    run(3 * PERIOD * SONG_LEN);
    checks++; if (q_cyc.size() < 2 * SONG_LEN + 1) begin errors++; $display("FAIL loop_count: got %0d want >= %0d", q_cyc.size(), 2 * SONG_LEN + 1); end
    for (int i = 0; i < q_cyc.size(); i++) begin
      checks++; if (q_l[i] !== scale(mem[i % SONG_LEN], vol) || q_r[i] !== q_l[i]) begin errors++; $display("FAIL loop_value[%0d]: got %h/%h want %h", i, q_l[i], q_r[i], scale(mem[i % SONG_LEN], vol)); end
      checks++; if (q_cyc[i] != s + RAM_LAT + 1 + i * PERIOD) begin errors++; $display("FAIL loop_timing[%0d]: got cycle %0d want %0d", i, q_cyc[i], s + RAM_LAT + 1 + i * PERIOD); end
    end
    audio_out_allowed = 0;
    run(2 * PERIOD);
    n = q_cyc.size();
    stop_pulse();
    l_hold = scale(mem[n % SONG_LEN], vol);
    run(4);
    checks++; if (playing !== 1'b0 || done !== 1'b0 || ram_addr !== '0) begin errors++; $display("FAIL loop_stop_idle: playing %b done %b addr %0d want 0/0/0", playing, done, ram_addr); end
    checks++; if (left_out !== l_hold || right_out !== l_hold) begin errors++; $display("FAIL loop_stop_hold: got %h/%h want %h", left_out, right_out, l_hold); end
  endtask

  task automatic test_backpressure();
    int s, w, bad;
    logic [DATA_W-1:0] exp0;
    loop_en = 0; audio_out_allowed = 0; vol = 3'($urandom_range(0, 7));
    for (int i = 0; i < SONG_LEN; i++) mem[i] = $urandom;
    exp0 = scale(mem[0], vol);
    clear_q();
    start_pulse(s);
    run(PERIOD + 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (left_out !== exp0 || ram_addr !== '0 || playing !== 1'b1) bad++;
      step();
    end
    checks++; if (bad != 0 || q_cyc.size() != 0) begin errors++; $display("FAIL bp_hold: unstable cycles %0d writes %0d want 0/0", bad, q_cyc.size()); end
    audio_out_allowed = 1;
    w = cyc;
    run(2);
    checks++; if (q_cyc.size() != 1) begin errors++; $display("FAIL bp_release_count: got %0d want 1", q_cyc.size()); end
    if (q_cyc.size() >= 1) begin
      checks++; if (q_l[0] !== exp0 || q_cyc[0] != w) begin errors++; $display("FAIL bp_release_write: got %h at %0d want %h at %0d", q_l[0], q_cyc[0], exp0, w); end
    end
    checks++; if (ram_addr !== ADDR_W'(1)) begin errors++; $display("FAIL bp_next_addr: got %0d want 1", ram_addr); end
    stop_pulse();
  endtask

  task automatic test_pause();
    int s, w;
    logic [DATA_W-1:0] exp0;
    loop_en = 0; audio_out_allowed = 1; pause = 1; vol = 3'($urandom_range(0, 7));
    for (int i = 0; i < SONG_LEN; i++) mem[i] = $urandom;
    exp0 = scale(mem[0], vol);
    clear_q();
    start_pulse(s);
    run(10);
    checks++; if (q_cyc.size() != 0 || playing !== 1'b1 || left_out !== exp0) begin errors++; $display("FAIL pause_hold: writes %0d playing %b sample %h want 0/1/%h", q_cyc.size(), playing, left_out, exp0); end
    pause = 0;
    w = cyc;
    run(PERIOD + 1);
    checks++; if (q_cyc.size() != 2) begin errors++; $display("FAIL pause_release_count: got %0d want 2", q_cyc.size()); end
    if (q_cyc.size() >= 2) begin
      checks++; if (q_l[0] !== exp0 || q_cyc[0] != w) begin errors++; $display("FAIL pause_release_write: got %h at %0d want %h at %0d", q_l[0], q_cyc[0], exp0, w); end
      checks++; if (q_l[1] !== scale(mem[1], vol) || q_cyc[1] != w + PERIOD) begin errors++; $display("FAIL pause_next_write: got %h at %0d want %h at %0d", q_l[1], q_cyc[1], scale(mem[1], vol), w + PERIOD); end
    end
    stop_pulse();
  endtask

  task automatic test_stop_start();
    int s;
    loop_en = 0; audio_out_allowed = 1; pause = 1;
    for (int i = 0; i < SONG_LEN; i++) mem[i] = $urandom;
    clear_q();
    start_pulse(s);
    run(PERIOD + 2);
    stop = 1; start = 1; pause = 0;
    #1;
    checks++; if (write_audio_out !== 1'b0) begin errors++; $display("FAIL stopstart_write: got %b want 0", write_audio_out); end
    step();
    stop = 0; start = 0;
    checks++; if (playing !== 1'b0 || done !== 1'b0 || ram_addr !== '0) begin errors++; $display("FAIL stopstart_idle: playing %b done %b addr %0d want 0/0/0", playing, done, ram_addr); end
    run(8);
    checks++; if (q_cyc.size() != 0 || playing !== 1'b0) begin errors++; $display("FAIL stopstart_no_restart: writes %0d playing %b want 0/0", q_cyc.size(), playing); end
  endtask

  task automatic test_volume();
    int s;
    logic [DATA_W-1:0] exp_v;
    exp_v = VOL_ON ? 32'hFFFF_F000 : 32'hFFFF_0000;
    loop_en = 0; audio_out_allowed = 1; pause = 1; vol = 3'd4;
    mem[0] = 32'hFFFF_0000;
    clear_q();
    start_pulse(s);
    run(PERIOD + 2);
    checks++; if (left_out !== exp_v || right_out !== exp_v) begin errors++; $display("FAIL volume_shift: got %h/%h want %h", left_out, right_out, exp_v); end
    pause = 0;
    stop_pulse();
  endtask

  task automatic test_random();
    int s, n;
    loop_en = 1; pause = 0; vol = 3'($urandom_range(0, 7));
    for (int i = 0; i < SONG_LEN; i++) mem[i] = $urandom;
    clear_q();
    audio_out_allowed = 1;
    start_pulse(s);
    for (int k = 0; k < 400; k++) begin
      audio_out_allowed = ($urandom_range(0, 3) != 0);
      pause = ($urandom_range(0, 4) == 0);
      start = ($urandom_range(0, 9) == 0);
      step();
    end
    start = 0; pause = 0; audio_out_allowed = 0;
    n = q_cyc.size();
    checks++; if (n < 40) begin errors++; $display("FAIL rand_progress: got %0d writes want >= 40", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (q_l[i] !== scale(mem[i % SONG_LEN], vol) || q_r[i] !== q_l[i]) begin errors++; $display("FAIL rand_value[%0d]: got %h/%h want %h", i, q_l[i], q_r[i], scale(mem[i % SONG_LEN], vol)); end
      if (i > 0) begin
        checks++; if (q_cyc[i] - q_cyc[i-1] < PERIOD) begin errors++; $display("FAIL rand_spacing[%0d]: got %0d want >= %0d", i, q_cyc[i] - q_cyc[i-1], PERIOD); end
      end
    end
    stop_pulse();
  endtask

  task automatic test_async_reset();
    int s, n;
    loop_en = 1; audio_out_allowed = 1; pause = 0;
    for (int i = 0; i < SONG_LEN; i++) mem[i] = $urandom;
    clear_q();
    start_pulse(s);
    run(2 * PERIOD + 1);
    #2 resetn = 1'b0;
    #1;
    checks++; if (playing !== 1'b0 || done !== 1'b0 || write_audio_out !== 1'b0) begin errors++; $display("FAIL areset_ctrl: playing %b done %b write %b want 0/0/0", playing, done, write_audio_out); end
    checks++; if (ram_addr !== '0 || left_out !== '0 || right_out !== '0) begin errors++; $display("FAIL areset_data: addr %0d ch %h/%h want 0/0/0", ram_addr, left_out, right_out); end
    n = q_cyc.size();
    step();
    resetn = 1'b1;
    run(6);
    checks++; if (playing !== 1'b0 || q_cyc.size() != n) begin errors++; $display("FAIL areset_idle_after: playing %b new writes %0d want 0/0", playing, q_cyc.size() - n); end
  endtask

  initial begin
    test_reset();
    test_play_once();
    test_loop();
    test_backpressure();
    test_pause();
    test_stop_start();
    test_volume();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
